// File: rtl/exception_unit_pkg.sv
// rtl/exception_unit_pkg.sv - shared constants and types for the MEM-stage exception arbiter
package exception_unit_pkg;

    localparam logic [31:0] EXC_NONE = 32'h0;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_TR   = 32'hd;
    localparam logic [31:0] EXC_ERET = 32'he;

    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;
    localparam int CAUSE_IP_HI    = 15;
    localparam int CAUSE_IP_LO    = 8;

    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'hBFC00380;
    localparam logic [4:0]  CP0_REG_STATUS     = 5'd12;
    localparam logic [4:0]  CP0_REG_CAUSE      = 5'd13;
    localparam logic [4:0]  CP0_REG_EPC        = 5'd14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } exc_state_e;

    function automatic logic [31:0] cp0_forward(input logic        we,
                                                input logic [4:0]  waddr,
                                                input logic [4:0]  reg_addr,
                                                input logic [31:0] wdata,
                                                input logic [31:0] cur);
        return (we && (waddr == reg_addr)) ? wdata : cur;
    endfunction

endpackage

// File: rtl/exception_unit_if.sv
// rtl/exception_unit_if.sv - MEM-stage exception inputs and CP0 commit outputs
interface exception_unit_if;

    logic        i_cache_stall;
    logic        inst_valid_i;
    logic [31:0] pc_i;
    logic        is_in_delayslot_i;
    logic        adel_if_i;
    logic        ri_i;
    logic        ov_i;
    logic        trap_i;
    logic        syscall_i;
    logic        break_i;
    logic        adel_mem_i;
    logic        ades_mem_i;
    logic        eret_i;
    logic [31:0] mem_addr_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic        cp0_we_i;
    logic [4:0]  cp0_waddr_i;
    logic [31:0] cp0_wdata_i;

    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic [31:0] bad_addr_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        busy_o;

    modport master (
        output i_cache_stall, inst_valid_i, pc_i, is_in_delayslot_i,
               adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i,
               adel_mem_i, ades_mem_i, eret_i, mem_addr_i,
               status_i, cause_i, epc_i, cp0_we_i, cp0_waddr_i, cp0_wdata_i,
        input  excepttype_o, current_inst_addr_o, is_in_delayslot_o,
               bad_addr_o, flush_o, new_pc_o, busy_o
    );

    modport slave (
        input  i_cache_stall, inst_valid_i, pc_i, is_in_delayslot_i,
               adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i,
               adel_mem_i, ades_mem_i, eret_i, mem_addr_i,
               status_i, cause_i, epc_i, cp0_we_i, cp0_waddr_i, cp0_wdata_i,
        output excepttype_o, current_inst_addr_o, is_in_delayslot_o,
               bad_addr_o, flush_o, new_pc_o, busy_o
    );

endinterface

// File: rtl/exception_unit_exc_priority_enc.sv
// rtl/exception_unit_exc_priority_enc.sv - combinational flag-to-cause encoder with BadVAddr select
module exc_priority_enc
    import exception_unit_pkg::*;
(
    input  logic        inst_valid,
    input  logic        int_pending,
    input  logic        adel_if,
    input  logic        ri,
    input  logic        ov,
    input  logic        trap,
    input  logic        syscall,
    input  logic        brk,
    input  logic        adel_mem,
    input  logic        ades_mem,
    input  logic        eret,
    input  logic [31:0] pc,
    input  logic [31:0] mem_addr,
    output logic [31:0] code,
    output logic [31:0] bad_addr
);

    always_comb begin
        code     = EXC_NONE;
        bad_addr = 32'h0;
        if (inst_valid) begin
            if (int_pending) begin
                code = EXC_INT;
            end else if (adel_if) begin
                code     = EXC_ADEL;
                bad_addr = pc;
            end else if (ri) begin
                code = EXC_RI;
            end else if (ov) begin
                code = EXC_OV;
            end else if (trap) begin
                code = EXC_TR;
            end else if (syscall) begin
                code = EXC_SYS;
            end else if (brk) begin
                code = EXC_BP;
            end else if (adel_mem) begin
                code     = EXC_ADEL;
                bad_addr = mem_addr;
            end else if (ades_mem) begin
                code     = EXC_ADES;
                bad_addr = mem_addr;
            end else if (eret) begin
                code = EXC_ERET;
            end
        end
    end

endmodule

// File: rtl/exception_unit.sv
// rtl/exception_unit.sv - MEM-stage exception arbiter driving CP0 commit, flush and redirect
module exception_unit
    import exception_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR      = DEFAULT_EXC_VECTOR,
    parameter logic [4:0]  CP0_STATUS_ADDR = CP0_REG_STATUS,
    parameter logic [4:0]  CP0_CAUSE_ADDR  = CP0_REG_CAUSE,
    parameter logic [4:0]  CP0_EPC_ADDR    = CP0_REG_EPC
)(
    input  logic              clk,
    input  logic              rst,
    exception_unit_if.slave   bus
);

    logic [31:0] eff_status;
    logic [31:0] eff_cause;
    logic [31:0] eff_epc;
    logic        int_pending;
    logic [31:0] dec_code;
    logic [31:0] dec_bad_addr;
    logic [31:0] dec_new_pc;
    logic        dec_hit;

    exc_state_e  state;
    exc_state_e  state_nx;
    logic        latch_en;

    logic [31:0] h_code;
    logic [31:0] h_pc;
    logic        h_ds;
    logic [31:0] h_bad_addr;
    logic [31:0] h_new_pc;

    // An mtc0 in the same instruction must be visible to its own exception check.
    assign eff_status = cp0_forward(bus.cp0_we_i, bus.cp0_waddr_i, CP0_STATUS_ADDR,
                                    bus.cp0_wdata_i, bus.status_i);
    assign eff_cause  = cp0_forward(bus.cp0_we_i, bus.cp0_waddr_i, CP0_CAUSE_ADDR,
                                    bus.cp0_wdata_i, bus.cause_i);
    assign eff_epc    = cp0_forward(bus.cp0_we_i, bus.cp0_waddr_i, CP0_EPC_ADDR,
                                    bus.cp0_wdata_i, bus.epc_i);

    assign int_pending = bus.inst_valid_i
                       & eff_status[STATUS_IE_BIT]
                       & ~eff_status[STATUS_EXL_BIT]
                       & (|(eff_cause[CAUSE_IP_HI:CAUSE_IP_LO] & eff_status[CAUSE_IP_HI:CAUSE_IP_LO]));

    logic unused_cp0_bits;
    assign unused_cp0_bits = ^{eff_status[31:16], eff_status[7:2],
                               eff_cause[31:16], eff_cause[7:0]};

    exc_priority_enc u_enc (
        .inst_valid  (bus.inst_valid_i),
        .int_pending (int_pending),
        .adel_if     (bus.adel_if_i),
        .ri          (bus.ri_i),
        .ov          (bus.ov_i),
        .trap        (bus.trap_i),
        .syscall     (bus.syscall_i),
        .brk         (bus.break_i),
        .adel_mem    (bus.adel_mem_i),
        .ades_mem    (bus.ades_mem_i),
        .eret        (bus.eret_i),
        .pc          (bus.pc_i),
        .mem_addr    (bus.mem_addr_i),
        .code        (dec_code),
        .bad_addr    (dec_bad_addr)
    );

    assign dec_hit    = (dec_code != EXC_NONE);
    assign dec_new_pc = (dec_code == EXC_ERET) ? eff_epc : EXC_VECTOR;
    assign latch_en   = (state == ST_IDLE) && dec_hit && bus.i_cache_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            h_code     <= 32'h0;
            h_pc       <= 32'h0;
            h_ds       <= 1'b0;
            h_bad_addr <= 32'h0;
            h_new_pc   <= 32'h0;
        end else begin
            state <= state_nx;
            if (latch_en) begin
                h_code     <= dec_code;
                h_pc       <= bus.pc_i;
                h_ds       <= bus.is_in_delayslot_i;
                h_bad_addr <= dec_bad_addr;
                h_new_pc   <= dec_new_pc;
            end
        end
    end

    always_comb begin
        state_nx                = state;
        bus.excepttype_o        = EXC_NONE;
        bus.current_inst_addr_o = 32'h0;
        bus.is_in_delayslot_o   = 1'b0;
        bus.bad_addr_o          = 32'h0;
        bus.flush_o             = 1'b0;
        bus.new_pc_o            = 32'h0;
        bus.busy_o              = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dec_hit) begin
                    bus.excepttype_o        = dec_code;
                    bus.current_inst_addr_o = bus.pc_i;
                    bus.is_in_delayslot_o   = bus.is_in_delayslot_i;
                    bus.bad_addr_o          = dec_bad_addr;
                    if (bus.i_cache_stall) begin
                        state_nx = ST_HOLD;
                    end else begin
                        bus.flush_o  = 1'b1;
                        bus.new_pc_o = dec_new_pc;
                        state_nx     = ST_DRAIN;
                    end
                end
            end
            ST_HOLD: begin
                bus.excepttype_o        = h_code;
                bus.current_inst_addr_o = h_pc;
                bus.is_in_delayslot_o   = h_ds;
                bus.bad_addr_o          = h_bad_addr;
                bus.busy_o              = 1'b1;
                if (!bus.i_cache_stall) begin
                    bus.flush_o  = 1'b1;
                    bus.new_pc_o = h_new_pc;
                    state_nx     = ST_DRAIN;
                end
            end
            // Outputs stay zero for one cycle so CP0 cannot commit twice during the flush.
            ST_DRAIN: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_exception_unit.sv
// tb/tb_exception_unit.sv - self-checking bench for exception_unit
module tb_exception_unit;

    logic clk;
    logic rst;

    exception_unit_if bus ();

    exception_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;

    // flags order: [8]adel_if [7]ri [6]ov [5]trap [4]syscall [3]break [2]adel_mem [1]ades_mem [0]eret
    typedef struct packed {
        logic        valid;
        logic [8:0]  flags;
        logic [31:0] pc;
        logic [31:0] mem_addr;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] exp_code;
        logic [31:0] exp_bad;
        logic [31:0] exp_npc;
    } vec_t;

    vec_t tv [0:9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic valid, input logic [8:0] flags, input logic [31:0] pc,
                         input logic [31:0] mem_addr, input logic [31:0] status,
                         input logic [31:0] cause, input logic [31:0] epc, input logic we,
                         input logic [4:0] waddr, input logic [31:0] wdata, input logic ds);
        bus.inst_valid_i      = valid;
        bus.adel_if_i         = flags[8];
        bus.ri_i              = flags[7];
        bus.ov_i              = flags[6];
        bus.trap_i            = flags[5];
        bus.syscall_i         = flags[4];
        bus.break_i           = flags[3];
        bus.adel_mem_i        = flags[2];
        bus.ades_mem_i        = flags[1];
        bus.eret_i            = flags[0];
        bus.pc_i              = pc;
        bus.mem_addr_i        = mem_addr;
        bus.status_i          = status;
        bus.cause_i           = cause;
        bus.epc_i             = epc;
        bus.cp0_we_i          = we;
        bus.cp0_waddr_i       = waddr;
        bus.cp0_wdata_i       = wdata;
        bus.is_in_delayslot_i = ds;
    endtask

    task automatic clear_inputs();
        drive(1'b0, 9'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference decode straight from the priority list.
    task automatic ref_decode(input logic valid, input logic [8:0] flags, input logic [31:0] pc,
                              input logic [31:0] mem_addr, input logic [31:0] status,
                              input logic [31:0] cause, input logic [31:0] epc, input logic we,
                              input logic [4:0] waddr, input logic [31:0] wdata,
                              output logic [31:0] code, output logic [31:0] bad,
                              output logic [31:0] npc);
        logic [31:0] es, ec, ee;
        logic        irq;
        logic [9:0]  req;
        int          codes [10];
        bit          found;
        codes = '{1, 4, 'ha, 'hc, 'hd, 8, 9, 4, 5, 'he};
        es = (we && waddr == 5'd12) ? wdata : status;
        ec = (we && waddr == 5'd13) ? wdata : cause;
        ee = (we && waddr == 5'd14) ? wdata : epc;
        irq = valid && es[0] && !es[1] && ((ec[15:8] & es[15:8]) != 8'h0);
        req = {irq, flags};
        code = 0;
        bad = 0;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (valid && !found && req[9-i]) begin
                found = 1;
                code = codes[i];
                if (i == 1) bad = pc;
                else if (i == 7 || i == 8) bad = mem_addr;
            end
        end
        npc = (code == 32'he) ? ee : 32'hBFC00380;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, ".code"},  bus.excepttype_o, 32'h0);
        chk({tag, ".flush"}, {31'h0, bus.flush_o}, 32'h0);
        chk({tag, ".npc"},   bus.new_pc_o, 32'h0);
        chk({tag, ".busy"},  {31'h0, bus.busy_o}, 32'h0);
        chk({tag, ".bad"},   bus.bad_addr_o, 32'h0);
    endtask

    // Random-phase model state
    bit          m_drain, m_hold;
    logic [31:0] mh_code, mh_pc, mh_bad, mh_npc;
    logic        mh_ds;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.i_cache_stall = 1'b0;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk_idle_zero("reset");
        chk("reset.pc", bus.current_inst_addr_o, 32'h0);
        step();

        tv[0] = '{1'b1, 9'b000010000, 32'hBFC00100, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                  32'h8, 32'h0, 32'hBFC00380};
        tv[1] = '{1'b1, 9'b001000000, 32'h80000010, 32'h0, 32'h0000FF01, 32'h00000400, 32'h0, 1'b0, 5'd0, 32'h0,
                  32'h1, 32'h0, 32'hBFC00380};
        tv[2] = '{1'b1, 9'b001000000, 32'h80000010, 32'h0, 32'h0000FF03, 32'h00000400, 32'h0, 1'b0, 5'd0, 32'h0,
                  32'hc, 32'h0, 32'hBFC00380};
        tv[3] = '{1'b1, 9'b000000001, 32'h80000020, 32'h0, 32'h0, 32'h0, 32'h80001000, 1'b1, 5'd14, 32'h80002000,
                  32'he, 32'h0, 32'h80002000};
        tv[4] = '{1'b0, 9'b111111111, 32'h80000030, 32'h44, 32'h0000FF01, 32'h0000FF00, 32'h0, 1'b0, 5'd0, 32'h0,
                  32'h0, 32'h0, 32'h0};
        tv[5] = '{1'b1, 9'b110000000, 32'h80000001, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                  32'h4, 32'h80000001, 32'hBFC00380};
        tv[6] = '{1'b1, 9'b000000010, 32'h80000040, 32'h00001234, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                  32'h5, 32'h00001234, 32'hBFC00380};
        tv[7] = '{1'b1, 9'b000101000, 32'h80000050, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                  32'hd, 32'h0, 32'hBFC00380};
        tv[8] = '{1'b1, 9'b000000001, 32'h80000060, 32'h0, 32'h0, 32'h00000100, 32'h80003000, 1'b1, 5'd12, 32'h0000FF01,
                  32'h1, 32'h0, 32'hBFC00380};
        tv[9] = '{1'b1, 9'b000000101, 32'h80000070, 32'h80000003, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                  32'h4, 32'h80000003, 32'hBFC00380};

        for (int i = 0; i < 10; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(tv[i].valid, tv[i].flags, tv[i].pc, tv[i].mem_addr, tv[i].status, tv[i].cause,
                  tv[i].epc, tv[i].we, tv[i].waddr, tv[i].wdata, 1'b0);
            @(negedge clk);
            chk({tag, ".code"},  bus.excepttype_o, tv[i].exp_code);
            chk({tag, ".bad"},   bus.bad_addr_o, tv[i].exp_bad);
            chk({tag, ".flush"}, {31'h0, bus.flush_o}, {31'h0, tv[i].exp_code != 32'h0});
            chk({tag, ".npc"},   bus.new_pc_o, tv[i].exp_npc);
            if (tv[i].exp_code != 32'h0)
                chk({tag, ".pc"}, bus.current_inst_addr_o, tv[i].pc);
            step();
            clear_inputs();
            @(negedge clk);
            chk_idle_zero({tag, ".drain"});
            step();
        end

        // Load misaligned held across a three-cycle stall, live inputs scrambled meanwhile
        drive(1'b1, 9'b000000100, 32'h80000100, 32'h80000003, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        bus.i_cache_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d.code", c), bus.excepttype_o, 32'h4);
            chk($sformatf("hold%0d.bad", c),  bus.bad_addr_o, 32'h80000003);
            chk($sformatf("hold%0d.pc", c),   bus.current_inst_addr_o, 32'h80000100);
            chk($sformatf("hold%0d.ds", c),   {31'h0, bus.is_in_delayslot_o}, 32'h1);
            chk($sformatf("hold%0d.flush", c), {31'h0, bus.flush_o}, 32'h0);
            if (c > 0) chk($sformatf("hold%0d.busy", c), {31'h0, bus.busy_o}, 32'h1);
            step();
            drive(1'b1, 9'b010000001, 32'h12345678, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        end
        bus.i_cache_stall = 1'b0;
        @(negedge clk);
        chk("hold.rel.flush", {31'h0, bus.flush_o}, 32'h1);
        chk("hold.rel.code",  bus.excepttype_o, 32'h4);
        chk("hold.rel.bad",   bus.bad_addr_o, 32'h80000003);
        chk("hold.rel.npc",   bus.new_pc_o, 32'hBFC00380);
        step();
        @(negedge clk);
        chk_idle_zero("hold.drain");
        step();
        clear_inputs();

        // Held eret keeps the EPC seen at latch time
        drive(1'b1, 9'b000000001, 32'h80000200, 32'h0, 32'h0, 32'h0, 32'h80004000, 1'b0, 5'd0, 32'h0, 1'b0);
        bus.i_cache_stall = 1'b1;
        step();
        bus.epc_i = 32'h80005000;
        bus.i_cache_stall = 1'b0;
        @(negedge clk);
        chk("eret_hold.npc", bus.new_pc_o, 32'h80004000);
        chk("eret_hold.code", bus.excepttype_o, 32'he);
        step();
        clear_inputs();
        step();

        // Reset while in HOLD
        drive(1'b1, 9'b000010000, 32'h80000300, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        bus.i_cache_stall = 1'b1;
        step();
        @(negedge clk);
        chk("rst_hold.busy", {31'h0, bus.busy_o}, 32'h1);
        rst = 1'b1;
        clear_inputs();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk_idle_zero("rst_hold");
        chk("rst_hold.pc", bus.current_inst_addr_o, 32'h0);
        bus.i_cache_stall = 1'b0;
        @(negedge clk);
        chk_idle_zero("rst_hold.after");
        step();

        // Randomized run against the behavioural model
        m_drain = 0;
        m_hold  = 0;
        for (int n = 0; n < 2000; n++) begin
            logic        v, we, ds, st;
            logic [8:0]  fl;
            logic [31:0] pc, ma, s, ca, ep, wd, dc, db, dn;
            logic [4:0]  wa;
            v  = ($urandom_range(0, 9) < 8);
            for (int b = 0; b < 9; b++) fl[b] = ($urandom_range(0, 9) == 0);
            pc = $urandom;
            ma = $urandom;
            s  = {$urandom} & 32'h0000FF03;
            ca = {$urandom} & 32'h0000FF00;
            ep = $urandom;
            we = $urandom_range(0, 1);
            wa = 5'($urandom_range(11, 15));
            wd = $urandom;
            ds = $urandom_range(0, 1);
            st = ($urandom_range(0, 9) < 4);
            drive(v, fl, pc, ma, s, ca, ep, we, wa, wd, ds);
            bus.i_cache_stall = st;
            ref_decode(v, fl, pc, ma, s, ca, ep, we, wa, wd, dc, db, dn);
            @(negedge clk);
            if (m_drain) begin
                chk_idle_zero("rnd.drain");
                m_drain = 0;
            end else if (m_hold) begin
                chk("rnd.hold.code", bus.excepttype_o, mh_code);
                chk("rnd.hold.bad",  bus.bad_addr_o, mh_bad);
                chk("rnd.hold.pc",   bus.current_inst_addr_o, mh_pc);
                chk("rnd.hold.ds",   {31'h0, bus.is_in_delayslot_o}, {31'h0, mh_ds});
                chk("rnd.hold.busy", {31'h0, bus.busy_o}, 32'h1);
                chk("rnd.hold.flush", {31'h0, bus.flush_o}, {31'h0, !st});
                chk("rnd.hold.npc",  bus.new_pc_o, st ? 32'h0 : mh_npc);
                if (!st) begin
                    m_hold  = 0;
                    m_drain = 1;
                end
            end else begin
                chk("rnd.code",  bus.excepttype_o, dc);
                chk("rnd.bad",   bus.bad_addr_o, db);
                chk("rnd.busy",  {31'h0, bus.busy_o}, 32'h0);
                chk("rnd.flush", {31'h0, bus.flush_o}, {31'h0, dc != 0 && !st});
                chk("rnd.npc",   bus.new_pc_o, (dc != 0 && !st) ? dn : 32'h0);
                if (dc != 0) begin
                    chk("rnd.pc", bus.current_inst_addr_o, pc);
                    chk("rnd.ds", {31'h0, bus.is_in_delayslot_o}, {31'h0, ds});
                    if (st) begin
                        m_hold  = 1;
                        mh_code = dc;
                        mh_bad  = db;
                        mh_pc   = pc;
                        mh_ds   = ds;
                        mh_npc  = dn;
                    end else begin
                        m_drain = 1;
                    end
                end
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
